tb_wait_event_mc: RTL and testbench

//  Multi-channel wait-event engine for the testbench sequencer; successor of the fixed 5-alias WAIT path.

---
 rtl/tb_wait_pkg.sv | 25 ++
 rtl/tb_wait_match.sv | 30 +++
 rtl/tb_wait_event_mc.sv | 149 ++++++++++++++
 tb/tb_tb_wait_event_mc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_wait_pkg.sv
// Shared types for the multi-channel wait-event engine.
`default_nettype none

package tb_wait_pkg;

  localparam int C_WAIT_MODE_W = 3;

  typedef enum logic [C_WAIT_MODE_W-1:0] {
    RISE     = 3'd0,
    FALL     = 3'd1,
    ANY_EDGE = 3'd2,
    HIGH     = 3'd3,
    LOW      = 3'd4
  } wait_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } wait_state_t;

endpackage

`default_nettype wire

// File: rtl/tb_wait_match.sv
// Combinational wait-condition decode: previous/current channel sample and mode
// produce a match flag, plus an illegal-mode flag for encodings above LOW.
`default_nettype none

module tb_wait_match
  import tb_wait_pkg::*;
(
  input  logic                     i_prev,
  input  logic                     i_cur,
  input  logic [C_WAIT_MODE_W-1:0] i_mode,
  output logic                     o_match,
  output logic                     o_illegal
);

  always_comb begin
    o_match   = 1'b0;
    o_illegal = 1'b0;
    case (i_mode)
      RISE:     o_match = ~i_prev & i_cur;
      FALL:     o_match = i_prev & ~i_cur;
      ANY_EDGE: o_match = i_prev ^ i_cur;
      HIGH:     o_match = i_cur;
      LOW:      o_match = ~i_cur;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tb_wait_event_mc.sv
// Multi-channel wait-event engine: waits for an edge/level on one selected
// channel with an optional cycle timeout, reporting done/timeout/error and elapsed cycles.
`default_nettype none

module tb_wait_event_mc
  import tb_wait_pkg::*;
#(
  parameter  int NB_CH     = 8,
  parameter  int TIMEOUT_W = 32,
  localparam int SEL_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NB_CH-1:0]         i_wait,
  input  logic                     i_start,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [C_WAIT_MODE_W-1:0] i_mode,
  input  logic [TIMEOUT_W-1:0]     i_timeout,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic                     o_err,
  output logic [TIMEOUT_W-1:0]     o_elapsed
);

  localparam int W_PAD = 2 ** SEL_W;

  wait_state_t                state_q, state_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [C_WAIT_MODE_W-1:0]   mode_q, mode_d;
  logic [TIMEOUT_W-1:0]       timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0]       elapsed_q, elapsed_d;
  logic                       prev_q, prev_d;
  logic                       tmo_q, tmo_d;
  logic                       err_q, err_d;

  logic [W_PAD-1:0]           w_wait_pad;
  logic                       w_cur;
  logic [C_WAIT_MODE_W-1:0]   w_mode;
  logic                       w_match;
  logic                       w_illegal;
  logic                       w_sel_bad;
  logic [TIMEOUT_W-1:0]       w_elapsed_inc;

  // Padding to a power of two keeps the mux in range for any NB_CH.
  assign w_wait_pad    = W_PAD'(i_wait);
  assign w_cur         = w_wait_pad[sel_q];
  assign w_mode        = (state_q == IDLE) ? i_mode : mode_q;
  assign w_sel_bad     = 32'(i_sel) >= NB_CH;
  assign w_elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + TIMEOUT_W'(1);

  tb_wait_match u_match (
    .i_prev    (prev_q),
    .i_cur     (w_cur),
    .i_mode    (w_mode),
    .o_match   (w_match),
    .o_illegal (w_illegal)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    elapsed_d = elapsed_q;
    prev_d    = prev_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          sel_d     = i_sel;
          mode_d    = i_mode;
          timeout_d = i_timeout;
          elapsed_d = '0;
          tmo_d     = 1'b0;
          err_d     = 1'b0;
          if (w_sel_bad || w_illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (i_abort) begin
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          prev_d  = w_cur;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_abort) begin
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          prev_d    = w_cur;
          elapsed_d = w_elapsed_inc;
          // A match in the expiry cycle is reported as an event, not a timeout.
          if (w_match) begin
            state_d = DONE;
          end else if ((timeout_q != '0) && (w_elapsed_inc == timeout_q)) begin
            tmo_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      mode_q    <= '0;
      timeout_q <= '0;
      elapsed_q <= '0;
      prev_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      elapsed_q <= elapsed_d;
      prev_q    <= prev_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign o_busy    = (state_q == ARM) || (state_q == WAIT);
  assign o_done    = (state_q == DONE);
  assign o_timeout = tmo_q;
  assign o_err     = err_q;
  assign o_elapsed = elapsed_q;

endmodule

`default_nettype wire

// File: tb/tb_tb_wait_event_mc.sv
// Scoreboard bench for tb_wait_event_mc: directed waits push expected completions,
// a negedge monitor pops and checks them whenever o_done pulses.
`default_nettype none

module tb_tb_wait_event_mc;
  import tb_wait_pkg::*;

  typedef struct {
    bit to;
    bit err;
    int el;
    int cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  i_wait;
  logic        i_start;
  logic [2:0]  i_sel;
  logic [2:0]  i_mode;
  logic [31:0] i_timeout;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;
  logic        o_err;
  logic [31:0] o_elapsed;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;

  tb_wait_event_mc dut (
    .clk       (clk),
    .rst       (rst),
    .i_wait    (i_wait),
    .i_start   (i_start),
    .i_sel     (i_sel),
    .i_mode    (i_mode),
    .i_timeout (i_timeout),
    .i_abort   (i_abort),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout),
    .o_err     (o_err),
    .o_elapsed (o_elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("done_timeout", o_timeout, mon_e.to);
        chk("done_err", o_err, mon_e.err);
        chk("done_elapsed", o_elapsed, mon_e.el);
        chk("done_busy", o_busy, 0);
      end
    end
  end

  // lat = cycles from the start-sampling edge to the edge entering DONE.
  task automatic start(input int sel, input int mode, input int to, input bit push,
                       input bit eto, input bit eerr, input int eel, input int lat);
    exp_t e;
    @(negedge clk);
    i_sel     = 3'(sel);
    i_mode    = 3'(mode);
    i_timeout = 32'(to);
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (push) begin
      e.to  = eto;
      e.err = eerr;
      e.el  = eel;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    chk("done_seen", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    i_wait    = '0;
    i_start   = 1'b0;
    i_sel     = '0;
    i_mode    = '0;
    i_timeout = '0;
    i_abort   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_timeout", o_timeout, 0);
    chk("reset_err", o_err, 0);
    chk("reset_elapsed", o_elapsed, 0);

    // RISE on ch3 arriving in WAIT cycle 10
    start(3, RISE, 100, 1, 0, 0, 10, 11);
    chk("busy_arm", o_busy, 1);
    repeat (10) @(posedge clk);
    #1 i_wait[3] = 1'b1;
    wait_idle();

    // FALL on ch0 that never comes: timeout after 20
    i_wait[0] = 1'b0;
    start(0, FALL, 20, 1, 1, 0, 20, 21);
    wait_idle();
    chk("timeout_hold", o_timeout, 1);

    // HIGH already true: minimum latency; abort during DONE is ignored
    i_wait[7] = 1'b1;
    start(7, HIGH, 0, 1, 0, 0, 1, 2);
    repeat (2) @(posedge clk);
    #1 i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    wait_idle();
    chk("elapsed_hold", o_elapsed, 1);

    // RISE with channel already high: no stale edge; ignored restart mid-wait
    i_wait[2] = 1'b1;
    start(2, RISE, 0, 1, 0, 0, 31, 32);
    repeat (15) @(posedge clk);
    #1;
    i_sel   = 3'd7;
    i_mode  = 3'(HIGH);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("busy_no_edge", o_busy, 1);
    i_wait[2] = 1'b0;
    @(posedge clk);
    #1 i_wait[2] = 1'b1;
    wait_idle();

    // illegal modes: error after one cycle
    start(0, 6, 10, 1, 0, 1, 0, 0);
    wait_idle();
    chk("err_hold", o_err, 1);
    start(1, 5, 0, 1, 0, 1, 0, 0);
    wait_idle();

    // ANY_EDGE coinciding with timeout expiry: event wins
    i_wait[1] = 1'b0;
    start(1, ANY_EDGE, 5, 1, 0, 0, 5, 6);
    repeat (5) @(posedge clk);
    #1 i_wait[1] = 1'b1;
    wait_idle();
    chk("err_cleared", o_err, 0);

    // ANY_EDGE with no edge: timeout at 5
    start(1, ANY_EDGE, 5, 1, 1, 0, 5, 6);
    wait_idle();

    // abort in WAIT: no done, flags cleared, elapsed frozen
    i_wait[4] = 1'b0;
    start(4, HIGH, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_elapsed", o_elapsed, 3);
    chk("abort_timeout", o_timeout, 0);
    repeat (3) @(posedge clk);
    #1 chk("abort_frozen", o_elapsed, 3);

    // abort in ARM
    start(4, HIGH, 0, 0, 0, 0, 0, 0);
    i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    chk("abort_arm_busy", o_busy, 0);
    chk("abort_arm_elapsed", o_elapsed, 0);

    // asynchronous reset mid-wait
    start(4, HIGH, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_elapsed", o_elapsed, 0);
    @(negedge clk);
    rst = 1'b0;

    // LOW level after reset recovery
    i_wait[5] = 1'b0;
    start(5, LOW, 0, 1, 0, 0, 1, 2);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
